i2s_receiver: RTL

- Slave-mode I2S receiver; the capture-side counterpart of the I2S transmit controller.
- Takes an external bit clock, word-select and serial data, and oversamples them with the system clock.
- Deserializes left/right samples (standard I2S format, MSB one bit clock after the LR edge) and buffers them in a small FIFO.
- Presents packed 32-bit words to the memory/wishbone side with a valid/ready handshake.

---
 rtl/i2s_receiver.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - slave-mode I2S capture into a first-word-fall-through word FIFO
// Oversamples bit clock, word select and data with clk; samples packed as {pad, channel, sample}.
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [31:0] memory_data,
  output logic        memory_data_strobe,
  input  logic        memory_ready,
  output logic        overflow,
  output logic        short_frame,
  input  logic        i2s_clock,
  input  logic        i2s_lr,
  input  logic        i2s_data
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [BW-1:0] PRE_LAST = BW'(SAMPLE_WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {SYNC, SHIFT, HOLD} state_t;

  logic [2:0] bclk_sync;
  logic [1:0] lr_sync;
  logic [1:0] data_sync;
  logic       lr_q;
  logic       bclk_rise;
  logic       lr_s;
  logic       data_s;
  logic       lr_edge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      data_sync <= '0;
      lr_q      <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], i2s_clock};
      lr_sync   <= {lr_sync[0], i2s_lr};
      data_sync <= {data_sync[0], i2s_data};
      // lr_q keeps tracking while disabled so re-alignment needs a real edge
      if (bclk_rise) lr_q <= lr_s;
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
  assign lr_s      = lr_sync[1];
  assign data_s    = data_sync[1];
  assign lr_edge   = bclk_rise & (lr_s != lr_q);

  state_t                  state_q, state_d;
  logic [BW-1:0]           count_q, count_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic                    chan_q, chan_d;
  logic                    push_q;
  logic                    sample_done;
  logic                    short_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SYNC;
      count_q <= '0;
      shift_q <= '0;
      chan_q  <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      chan_q  <= chan_d;
      push_q  <= sample_done;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    chan_d      = chan_q;
    sample_done = 1'b0;
    short_set   = 1'b0;
    if (!enable) begin
      state_d = SYNC;
      count_d = '0;
      shift_d = '0;
    end else if (bclk_rise) begin
      case (state_q)
        SYNC, HOLD: begin
          if (lr_edge) begin
            state_d = SHIFT;
            count_d = '0;
            shift_d = '0;
            chan_d  = lr_s;
          end
        end
        SHIFT: begin
          // the bit on an edge rise belongs to the previous slot and is dropped
          if (lr_edge) begin
            short_set = 1'b1;
            count_d   = '0;
            shift_d   = '0;
            chan_d    = lr_s;
          end else begin
            shift_d = {shift_q[SAMPLE_WIDTH-2:0], data_s};
            count_d = count_q + BW'(1);
            if (count_q == PRE_LAST) begin
              state_d     = HOLD;
              sample_done = 1'b1;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  logic [31:0] push_word;

  always_comb begin
    push_word                   = '0;
    push_word[SAMPLE_WIDTH-1:0] = shift_q;
    push_word[SAMPLE_WIDTH]     = chan_q;
  end

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] fifo_count, remain;
  logic          pop, full, wr_en, ovf_set;

  assign pop     = memory_data_strobe & memory_ready;
  assign full    = (fifo_count == FULL_CNT);
  assign wr_en   = enable & push_q & (~full | pop);
  assign ovf_set = push_q & full & ~pop;
  // remain excludes this edge's push, so a fresh word shows one clk after it lands
  assign remain  = fifo_count - CW'(pop);
  assign rd_next = rd_ptr + AW'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_count         <= '0;
      memory_data        <= '0;
      memory_data_strobe <= 1'b0;
      overflow           <= 1'b0;
      short_frame        <= 1'b0;
    end else if (!enable) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_count         <= '0;
      memory_data        <= '0;
      memory_data_strobe <= 1'b0;
      overflow           <= 1'b0;
      short_frame        <= 1'b0;
    end else begin
      wr_ptr             <= wr_ptr + AW'(wr_en);
      rd_ptr             <= rd_next;
      fifo_count         <= fifo_count + CW'(wr_en) - CW'(pop);
      memory_data_strobe <= (remain != '0);
      memory_data        <= (remain != '0) ? mem[rd_next] : '0;
      if (ovf_set)   overflow    <= 1'b1;
      if (short_set) short_frame <= 1'b1;
    end
  end

endmodule
